ring_fifo: RTL and testbench
============================

Name: ring_fifo

Overview:
- Parametrised successor to the shift-register FIFO: a circular-buffer FIFO with read/write pointers, so pops no longer shift storage.
- Uses valid/ready handshakes on both sides, first-word-fall-through output, almost-full/almost-empty flags, synchronous flush, and a peak-occupancy watermark.
- Drop-in buffering stage between pipeline units (fetch queue, memory request/response queues).

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 1, almost_empty asserts when count <= this value (0..DEPTH-1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  WIDTH  head entry, first-word-fall-through.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- peak  out  $clog2(DEPTH)+1  highest count reached since reset or last flush.

Behaviour:
- Reset (asynchronous, immediate, overrides everything): wr_ptr=0, rd_ptr=0, count=0, peak=0, all storage entries cleared to 0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, almost_full=0 (if AFULL_THRESH>0), almost_empty=1.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so there is no pass-through when full.
- out_valid = (count != 0). out_data = mem[rd_ptr], driven combinationally from the registered state.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- push: mem[wr_ptr] <= in_data; wr_ptr advances.
- pop: rd_ptr advances.
- Pointer advance: ptr == DEPTH-1 wraps to 0, otherwise ptr+1. Use explicit compare, not power-of-two masking.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop: count unchanged; both pointers advance.
  - neither: hold.
- Full (count=DEPTH): in_ready=0. in_valid is ignored, with no write and no error.
- Empty (count=0): out_valid=0. out_ready is ignored. A push into an empty FIFO makes out_valid=1 with out_data = that word on the next cycle (latency 1).
- Minimum latency in->out is 1 cycle. Sustained throughput is 1 word/cycle at any occupancy 1..DEPTH-1.
- Handshake rules for the producer: in_data must be held stable while in_valid=1 and in_ready=0. The producer may drop in_valid without a transfer. The FIFO never drops or duplicates an accepted word.
- flush (synchronous, highest priority after rst): next cycle wr_ptr=rd_ptr=0, count=0, peak=0. A push or pop in the same cycle as flush is discarded. Storage contents are not cleared by flush.
- peak: on each edge, peak <= max(peak, next count). It is monotonic until reset or flush.
- almost_full and almost_empty are decoded combinationally from the count register, so they change one cycle after the push or pop that causes them.
- Reset mid-operation: all state is cleared immediately, regardless of clk. Handshakes in flight are lost.

Test Plan:
- DEPTH=5, WIDTH=8. After reset, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles with out_ready=0 -> count 1..5; in_ready=0 after the 5th; almost_full=1 from count=4; peak=5.
- From full, hold in_valid=1 with in_data=0x66 and out_ready=0 for 3 cycles -> count stays 5, no write. Then pop 5 -> out_data sequence 0x11..0x55, out_valid=0 afterwards, 0x66 accepted only once in_ready=1.
- Wrap test: push and pop continuously for 12 cycles with incrementing data 0x00..0x0B while occupancy is 2 -> output order matches input exactly, count constant at 2 (pointers wrap past index 4).
- Empty-side timing: push 0xA5 into an empty FIFO with out_ready=1 -> out_valid rises on the next cycle with out_data=0xA5, pop occurs there, count returns to 0.
- Flush with simultaneous push and pop at count=3 -> next cycle count=0, peak=0, out_valid=0, in_ready=1, and the pushed word is never output.
- Assert rst asynchronously mid-burst between clock edges at count=4 -> count, peak and out_valid go to 0 immediately and out_data=0. After rst is released, normal operation resumes from an empty FIFO.

Source files
------------

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides, first-word-fall-through
// output, almost-full/empty flags, synchronous flush and a peak watermark.
module ring_fifo #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     peak
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // DEPTH need not be a power of two, so wrap on an explicit compare
    function automatic ptr_t adv(input ptr_t p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count_nxt;
    logic             push;
    logic             pop;

    assign in_ready     = (count != CW'(DEPTH));
    assign out_valid    = (count != '0);
    assign out_data     = mem[rd_ptr];
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign almost_full  = (count >= CW'(AFULL_THRESH));
    assign almost_empty = (count <= CW'(AEMPTY_THRESH));

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else begin
            if (push) wr_ptr <= adv(wr_ptr);
            if (pop)  rd_ptr <= adv(rd_ptr);
            count <= count_nxt;
            if (count_nxt > peak) peak <= count_nxt;
        end
    end

    // Storage survives flush; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo (DEPTH=5, WIDTH=8) with a queue scoreboard
// that records accepted words and checks them as they are popped.
module tb_ring_fifo;

    localparam int W = 8;
    localparam int D = 5;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   count;
    logic         almost_full;
    logic         almost_empty;
    logic [3:0]   peak;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];

    ring_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .peak(peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Called at negedge: score the handshakes of this cycle, then clock
    task automatic tick();
        logic [W-1:0] e;
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_data", 32'(out_data), 32'(e));
        end
        if (in_valid && in_ready) q.push_back(in_data);
        @(posedge clk);
        @(negedge clk);
        chk("sb_count", 32'(count), 32'(q.size()));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_peak", 32'(peak), 0);
        @(negedge clk);
        rst = 1'b0;

        // fill to full
        for (int i = 0; i < D; i++) begin
            in_valid = 1'b1;
            in_data = W'(8'h11 * (i + 1));
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 4));
            chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 1));
        end
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_peak", 32'(peak), 5);

        // push against full is ignored
        in_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold", 32'(count), 5);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) tick();
        chk("drain_out_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("late_66", 32'(out_data), 32'h66);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("peak_hold", 32'(peak), 5);

        // wrap with occupancy 2
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hE0;
        tick();
        in_data = 8'hE1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = W'(i);
            tick();
            chk("wrap_count", 32'(count), 2);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("wrap_q_empty", 32'(q.size()), 0);

        // push into empty with out_ready high
        in_valid = 1'b1;
        in_data = 8'hA5;
        tick();
        chk("fwft_valid", 32'(out_valid), 1);
        chk("fwft_data", 32'(out_data), 32'hA5);
        in_valid = 1'b0;
        tick();
        chk("fwft_count", 32'(count), 0);

        // flush with simultaneous push and pop at count 3
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(8'hC1 + i);
            tick();
        end
        flush = 1'b1;
        in_data = 8'h77;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        chk("flush_count", 32'(count), 0);
        chk("flush_peak", 32'(peak), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;
        in_data = 8'h88;
        tick();
        chk("post_flush_peak", 32'(peak), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // async reset mid-burst at count 4
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'(8'hD1 + i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_peak", 32'(peak), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick();
        chk("resume_data", 32'(out_data), 32'h5A);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("resume_empty", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
